fir_output_stage: RTL and testbench

- Sits directly downstream of the FIR tap chain and consumes the final tap's accumulator output (IW = 40-bit signed sum for 16x16 taps plus 8 guard bits).
- Per accepted sample: optional decimation, round-half-up, arithmetic right shift, saturation to OW bits.
- Buffers results in a small first-word-fall-through FIFO, exposed to the accelerator's bus/DMA side over a valid/ready handshake.
- Provides sticky saturation and overrun flags for status registers.

---
 rtl/fir_output_stage_if.sv | 21 ++
 rtl/fir_output_stage.sv | 151 +++++++++++++++
 tb/tb_fir_output_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_output_stage_if.sv
//------------------------------------------------------------------------------
// fir_output_stage_if : valid/ready sample stream with FIFO occupancy. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fir_output_stage_if #(
  parameter int OW    = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          valid;
  logic          ready;
  logic [OW-1:0] data;
  logic [LW-1:0] level;

  modport master (output valid, output data, output level, input ready);
  modport slave  (input valid, input data, input level, output ready);
endinterface

`default_nettype wire

// File: rtl/fir_output_stage.sv
//------------------------------------------------------------------------------
// fir_output_stage : decimate, round, shift, saturate, buffer FIR sums. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_output_stage #(
  parameter int IW    = 40,
  parameter int OW    = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic signed [IW-1:0] acc,
  input  logic [DW-1:0]        decim,
  input  logic                 clr_flags,
  output logic                 sat,
  output logic                 overrun,
  fir_output_stage_if.master   dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_depth = LW'(DEPTH);

  localparam logic signed [IW:0] c_round = {{(IW+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IW:0] c_max   = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] c_min   = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  logic [DW-1:0]        r_cnt;
  logic                 w_accept;
  logic signed [IW:0]   w_ext;
  logic signed [IW:0]   w_rnd;
  logic signed [IW:0]   w_shr;
  logic                 w_hi;
  logic                 w_lo;
  logic [OW-1:0]        w_res;

  logic                 r_stg_vld;
  logic [OW-1:0]        r_stg_data;

  logic [OW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [OW-1:0]        r_hold;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // Decimation: a sample is taken whenever the countdown is at zero
  assign w_accept = ce && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ce) begin
      r_cnt <= (r_cnt == '0) ? decim : r_cnt - DW'(1);
    end
  end

  // One extra bit of headroom so the rounding add can never wrap
  assign w_ext = {acc[IW-1], acc};
  assign w_rnd = w_ext + c_round;
  assign w_shr = w_rnd >>> SHIFT;
  assign w_hi  = w_shr > c_max;
  assign w_lo  = w_shr < c_min;

  always_comb begin
    w_res = w_shr[OW-1:0];
    if (w_hi) begin
      w_res = {1'b0, {(OW-1){1'b1}}};
    end else if (w_lo) begin
      w_res = {1'b1, {(OW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_vld  <= 1'b0;
      r_stg_data <= '0;
    end else begin
      r_stg_vld <= w_accept;
      if (w_accept) begin
        r_stg_data <= w_res;
      end
    end
  end

  assign w_full = (r_level == c_depth);
  assign w_pop  = (r_level != '0) && dout.ready;
  assign w_push = r_stg_vld && (!w_full || w_pop);
  assign w_drop = r_stg_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_stg_data;
    end
  end

  // r_hold keeps the last popped word visible once the FIFO runs dry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_hold   <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (w_accept && (w_hi || w_lo)) begin
        sat <= 1'b1;
      end else if (clr_flags) begin
        sat <= 1'b0;
      end
      if (w_drop) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
    end
  end

  assign dout.valid = (r_level != '0);
  assign dout.level = r_level;
  assign dout.data  = (r_level != '0) ? r_mem[r_rd_ptr] : r_hold;

endmodule

`default_nettype wire

// File: tb/tb_fir_output_stage.sv
//------------------------------------------------------------------------------
// tb_fir_output_stage : directed plus random checks against a queue model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_output_stage;

  localparam int IW    = 40;
  localparam int OW    = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 ce        = 1'b0;
  logic signed [IW-1:0] acc       = '0;
  logic [DW-1:0]        decim     = '0;
  logic                 clr_flags = 1'b0;
  logic                 sat;
  logic                 overrun;

  fir_output_stage_if #(.OW(OW), .DEPTH(DEPTH)) bus ();

  fir_output_stage #(
    .IW(IW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH), .DW(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .acc       (acc),
    .decim     (decim),
    .clr_flags (clr_flags),
    .sat       (sat),
    .overrun   (overrun),
    .dout      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int     m_skip;
  bit     m_sv;
  longint m_sval;
  longint m_q[$];
  longint m_last;
  bit     m_sat;
  bit     m_ovr;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round half up, floor-divide by 2^SHIFT, clamp to the signed output range
  function automatic longint exp_out(input longint a, output bit clip);
    longint r;
    longint hi;
    longint lo;
    hi   = (longint'(1) << (OW-1)) - 1;
    lo   = -(longint'(1) << (OW-1));
    r    = (a + (longint'(1) << (SHIFT-1))) >>> SHIFT;
    clip = (r > hi) || (r < lo);
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic model_reset();
    m_skip = 0;
    m_sv   = 1'b0;
    m_sval = 0;
    m_q.delete();
    m_last = 0;
    m_sat  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge();
    bit     pop, full, push, drop, take, clip;
    longint v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop  = (m_q.size() > 0) && bus.ready;
    full = (m_q.size() == DEPTH);
    push = m_sv && (!full || pop);
    drop = m_sv && full && !pop;
    take = ce && (m_skip == 0);
    v    = exp_out(longint'(acc), clip);
    if (pop)  m_last = m_q.pop_front();
    if (push) m_q.push_back(m_sval);
    if (drop) m_ovr = 1'b1;
    else if (clr_flags) m_ovr = 1'b0;
    if (take && clip) m_sat = 1'b1;
    else if (clr_flags) m_sat = 1'b0;
    m_sv = take;
    if (take) m_sval = v;
    if (ce) m_skip = (m_skip == 0) ? int'(decim) : m_skip - 1;
  endtask

  task automatic compare_all();
    check("valid",   bus.valid, m_q.size() > 0);
    check("level",   bus.level, m_q.size());
    check("data",    $signed(bus.data), (m_q.size() > 0) ? m_q[0] : m_last);
    check("sat",     sat, m_sat);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  longint rnd_acc[6] = '{16384, 16383, -16384, -16385, 64'sd2147483648, -(64'sd1 <<< 39)};
  longint rnd_exp[6] = '{1, 0, 0, -1, 32767, -32768};

  initial begin
    longint t;
    int     sel;
    model_reset();
    bus.ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_data", $signed(bus.data), 0);
    rst_n = 1'b1;

    // Rounding and saturation, one sample at a time
    decim     = '0;
    bus.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ce  = 1'b1;
      acc = rnd_acc[i][IW-1:0];
      tick();
      ce = 1'b0;
      tick();
      check("round_data",  $signed(bus.data), rnd_exp[i]);
      check("round_valid", bus.valid, 1);
      if (i < 4) check("round_nosat", sat, 0);
      tick();
    end
    check("sat_set", sat, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("sat_clr", sat, 0);

    // Decimation by 4, switched to 1 mid-run
    decim = 8'd3;
    ce    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 9) decim = '0;
      t   = longint'(k) * 32768;
      acc = t[IW-1:0];
      tick();
    end
    ce = 1'b0;
    repeat (3) tick();

    // Back-pressure and overrun
    bus.ready = 1'b0;
    ce        = 1'b1;
    for (int i = 0; i < 6; i++) begin
      t   = longint'(100 + i) * 32768;
      acc = t[IW-1:0];
      tick();
    end
    ce = 1'b0;
    repeat (2) tick();
    check("ovr_level", bus.level, 4);
    check("ovr_flag",  overrun, 1);
    check("ovr_head",  $signed(bus.data), 100);
    bus.ready = 1'b1;
    repeat (5) tick();
    check("drain_empty", bus.valid, 0);
    check("drain_last",  $signed(bus.data), 103);

    // Full FIFO with a simultaneous push and pop
    clr_flags = 1'b1;
    bus.ready = 1'b0;
    ce        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t   = longint'(200 + i) * 32768;
      acc = t[IW-1:0];
      tick();
    end
    ce = 1'b0;
    tick();
    ce  = 1'b1;
    t   = longint'(300) * 32768;
    acc = t[IW-1:0];
    tick();
    ce        = 1'b0;
    bus.ready = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("fullpop_level", bus.level, 4);
    check("fullpop_ovr",   overrun, 0);
    check("fullpop_head",  $signed(bus.data), 201);
    repeat (6) tick();

    // Asynchronous reset with three entries buffered and the counter mid-count
    bus.ready = 1'b0;
    decim     = '0;
    ce        = 1'b1;
    t   = longint'(1) <<< 32;
    acc = t[IW-1:0];
    tick();
    t   = longint'(11) * 32768;
    acc = t[IW-1:0];
    tick();
    decim = 8'd5;
    tick();
    ce = 1'b0;
    tick();
    check("pre_rst_level", bus.level, 3);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("arst_valid", bus.valid, 0);
    check("arst_sat",   sat, 0);
    tick();
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    ce        = 1'b1;
    t   = longint'(7) * 32768;
    acc = t[IW-1:0];
    tick();
    ce = 1'b0;
    tick();
    check("post_rst_data",  $signed(bus.data), 7);
    check("post_rst_valid", bus.valid, 1);
    tick();

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      ce        = ($urandom_range(0, 3) != 0);
      decim     = DW'($urandom_range(0, 2));
      bus.ready = ($urandom_range(0, 99) < ((i < 200) ? 30 : 80));
      clr_flags = ($urandom_range(0, 19) == 0);
      sel       = int'($urandom_range(0, 3));
      case (sel)
        0: t = longint'({$urandom, $urandom});
        1: t = longint'($urandom_range(0, 2097152)) - 1048576;
        2: t = (longint'($urandom_range(0, 2000)) - 1000) * 32768 + 16384
               - longint'($urandom_range(0, 1));
        default: begin
          t = 32767 * 32768 + 16384 - longint'($urandom_range(0, 1));
          if ($urandom_range(0, 1) != 0) t = -t - 2;
          if ($urandom_range(0, 3) == 0) t = t + (longint'($urandom_range(0, 255)) <<< 30);
        end
      endcase
      acc = t[IW-1:0];
      tick();
    end
    ce = 1'b0;
    bus.ready = 1'b1;
    clr_flags = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
